wb_ctrl: RTL and testbench

Writeback controller for the RV32I core. It is the writer that drives the register file's write port (wrEn/wrAddr/wrData).
- Accepts ALU results and load issues from the execute stage through a valid/ready handshake.
- Tracks outstanding loads in an in-order pending FIFO and aligns/extends returning memory data.
- Arbitrates both sources onto the single write port.
- Exports a busy mask that decode uses for load-use stalls.

---
 rtl/wb_pkg.sv | 54 +++++
 rtl/wb_ctrl_pend_fifo.sv | 96 +++++++++
 rtl/wb_ctrl.sv | 160 ++++++++++++++++
 tb/tb_wb_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Writeback controller shared definitions.
// Contents:
//   F3_*        RV32I load funct3 encodings
//   pend_t      one pending load: destination register, funct3, byte offset
//   align_t     aligned/extended load data plus an illegal-funct3 flag
//   load_align  selects the byte/half/word of a returned memory word and
//               sign- or zero-extends it to 32 bits
package wb_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [1:0] addr_lo;
    } pend_t;

    localparam int PEND_W = $bits(pend_t);

    typedef struct packed {
        logic [31:0] data;
        logic        illegal;
    } align_t;

    function automatic align_t load_align(input pend_t p, input logic [31:0] d);
        align_t      r;
        logic [7:0]  b;
        logic [15:0] h;
        case (p.addr_lo)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        // Halfword loads only look at addr[1]; addr[0] is ignored.
        h = p.addr_lo[1] ? d[31:16] : d[15:0];
        r.data    = '0;
        r.illegal = 1'b0;
        case (p.funct3)
            F3_LB:   r.data = {{24{b[7]}}, b};
            F3_LBU:  r.data = {24'd0, b};
            F3_LH:   r.data = {{16{h[15]}}, h};
            F3_LHU:  r.data = {16'd0, h};
            F3_LW:   r.data = d;
            default: r.illegal = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/wb_ctrl_pend_fifo.sv
// In-order FIFO of pending loads.
// Ports:
//   clk, rst     clock, synchronous active-high reset (empties the FIFO)
//   push         enqueue push_data (ignored when full)
//   push_data    pending-load descriptor
//   pop          dequeue the head (ignored when empty)
//   head         oldest entry
//   full, empty  occupancy flags derived from count
//   count        number of valid entries (0..LD_DEPTH)
//   entry_rd     destination register of every slot, slot i at [5*i +: 5]
//   entry_valid  per-slot valid bit, used for the busy-mask decode
module pend_fifo
    import wb_pkg::*;
#(
    parameter  int LD_DEPTH = 4,
    localparam int PTR_W    = $clog2(LD_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  pend_t                 push_data,
    input  logic                  pop,
    output pend_t                 head,
    output logic                  full,
    output logic                  empty,
    output logic [PTR_W:0]        count,
    output logic [LD_DEPTH*5-1:0] entry_rd,
    output logic [LD_DEPTH-1:0]   entry_valid
);

    pend_t               mem_q [LD_DEPTH];
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]      count_q, count_d;
    logic [LD_DEPTH-1:0] valid_q, valid_d;
    logic                push_ok, pop_ok;

    assign full  = (count_q == (PTR_W+1)'(LD_DEPTH));
    assign empty = (count_q == '0);

    // A push is refused when full even if a pop frees a slot this cycle.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        valid_d  = valid_q;
        if (pop_ok) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + 1'b1;
        end
        if (push_ok) begin
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    // Storage needs no reset: every consumer qualifies it with valid_q.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head        = mem_q[rd_ptr_q];
    assign count       = count_q;
    assign entry_valid = valid_q;

    generate
        for (genvar gi = 0; gi < LD_DEPTH; gi++) begin : g_entry
            assign entry_rd[gi*5 +: 5] = mem_q[gi].rd;
        end
    endgenerate

endmodule

// File: rtl/wb_ctrl.sv
// Writeback controller: the single writer of the register-file write port.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   exValid/exReady          execute-stage handshake
//   exIsLoad                 1 = load issue, 0 = ALU result
//   exRdAddr, exData         destination register, ALU result
//   exFunct3, exAddrLo       load type and byte offset
//   memRspValid, memRspData  in-order load data return (no backpressure)
//   wrEn, wrAddr, wrData     registered register-file write port
//   busyMask                 registers targeted by pending loads
//   ldCount                  number of pending loads
//   errFlag                  sticky: orphan response or illegal load funct3
// Priority for the write port: load response, then held ALU result, then a
// new ALU result.
module wb_ctrl
    import wb_pkg::*;
#(
    parameter  int LD_DEPTH = 4,
    localparam int PTR_W    = $clog2(LD_DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           exValid,
    output logic           exReady,
    input  logic           exIsLoad,
    input  logic [4:0]     exRdAddr,
    input  logic [31:0]    exData,
    input  logic [2:0]     exFunct3,
    input  logic [1:0]     exAddrLo,
    input  logic           memRspValid,
    input  logic [31:0]    memRspData,
    output logic           wrEn,
    output logic [4:0]     wrAddr,
    output logic [31:0]    wrData,
    output logic [31:0]    busyMask,
    output logic [PTR_W:0] ldCount,
    output logic           errFlag
);

    pend_t                 head;
    pend_t                 push_data;
    logic                  fifo_full, fifo_empty;
    logic [LD_DEPTH*5-1:0] entry_rd;
    logic [LD_DEPTH-1:0]   entry_valid;
    logic                  xfer, push, pop, alu_wr;
    align_t                aligned;

    logic        hold_valid_q, hold_valid_d;
    logic [4:0]  hold_rd_q, hold_rd_d;
    logic [31:0] hold_data_q, hold_data_d;
    logic        wr_en_q, wr_en_d;
    logic [4:0]  wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic        err_q, err_d;

    assign exReady   = !rst && !hold_valid_q && !(exIsLoad && fifo_full);
    assign xfer      = exValid && exReady;
    assign push      = xfer && exIsLoad;
    assign pop       = memRspValid && !fifo_empty;
    // ALU results for x0 are accepted but never need a write slot.
    assign alu_wr    = xfer && !exIsLoad && (exRdAddr != 5'd0);
    assign push_data = '{rd: exRdAddr, funct3: exFunct3, addr_lo: exAddrLo};
    assign aligned   = load_align(head, memRspData);

    pend_fifo #(.LD_DEPTH(LD_DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_data   (push_data),
        .pop         (pop),
        .head        (head),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .count       (ldCount),
        .entry_rd    (entry_rd),
        .entry_valid (entry_valid)
    );

    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_rd_d    = hold_rd_q;
        hold_data_d  = hold_data_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        err_d        = err_q;
        if (memRspValid) begin
            if (fifo_empty) begin
                err_d = 1'b1;
            end else begin
                if (aligned.illegal) begin
                    err_d = 1'b1;
                end
                if (head.rd != 5'd0) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = head.rd;
                    wr_data_d = aligned.data;
                end
            end
            // The response owns the port; park a colliding ALU result.
            if (alu_wr) begin
                hold_valid_d = 1'b1;
                hold_rd_d    = exRdAddr;
                hold_data_d  = exData;
            end
        end else if (hold_valid_q) begin
            wr_en_d      = 1'b1;
            wr_addr_d    = hold_rd_q;
            wr_data_d    = hold_data_q;
            hold_valid_d = 1'b0;
        end else if (alu_wr) begin
            wr_en_d   = 1'b1;
            wr_addr_d = exRdAddr;
            wr_data_d = exData;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_q <= 1'b0;
            hold_rd_q    <= '0;
            hold_data_q  <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_rd_q    <= hold_rd_d;
            hold_data_q  <= hold_data_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            err_q        <= err_d;
        end
    end

    assign wrEn    = wr_en_q;
    assign wrAddr  = wr_addr_q;
    assign wrData  = wr_data_q;
    assign errFlag = err_q;

    // One-hot decode of each valid entry's rd, OR-reduced across entries.
    logic [31:0] dec [LD_DEPTH];

    generate
        for (genvar gi = 0; gi < LD_DEPTH; gi++) begin : g_dec
            assign dec[gi] = entry_valid[gi] ? (32'd1 << entry_rd[gi*5 +: 5]) : 32'd0;
        end
    endgenerate

    always_comb begin
        busyMask = 32'd0;
        for (int i = 0; i < LD_DEPTH; i++) begin
            busyMask = busyMask | dec[i];
        end
        busyMask[0] = 1'b0;
    end

endmodule

// File: tb/tb_wb_ctrl.sv
module tb_wb_ctrl;

    localparam int LD_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_is_load, mem_rsp_valid;
    logic [4:0]  ex_rd;
    logic [31:0] ex_data, mem_rsp_data;
    logic [2:0]  ex_f3;
    logic [1:0]  ex_lo;
    logic        ex_ready, wr_en, err_flag;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data, busy_mask;
    logic [2:0]  ld_count;

    always #5 clk = ~clk;

    wb_ctrl #(.LD_DEPTH(LD_DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .exValid     (ex_valid),
        .exReady     (ex_ready),
        .exIsLoad    (ex_is_load),
        .exRdAddr    (ex_rd),
        .exData      (ex_data),
        .exFunct3    (ex_f3),
        .exAddrLo    (ex_lo),
        .memRspValid (mem_rsp_valid),
        .memRspData  (mem_rsp_data),
        .wrEn        (wr_en),
        .wrAddr      (wr_addr),
        .wrData      (wr_data),
        .busyMask    (busy_mask),
        .ldCount     (ld_count),
        .errFlag     (err_flag)
    );

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    // Reference state: pending loads as a plain queue, the deferred ALU
    // result, and the write expected on the port after the last edge.
    typedef struct {
        int rd;
        int f3;
        int lo;
    } ld_t;

    ld_t         pend_q[$];
    bit          m_hold;
    int          m_hold_rd;
    logic [31:0] m_hold_data;
    bit          m_wr_en;
    int          m_wr_addr;
    logic [31:0] m_wr_data;
    bit          m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // {illegal, data} from shifting and masking the word.
    function automatic logic [32:0] ref_load(input int f3, input int lo, input logic [31:0] d);
        logic [31:0] b;
        logic [31:0] h;
        b = (d >> (8 * lo)) & 32'hFF;
        h = (d >> (16 * (lo / 2))) & 32'hFFFF;
        case (f3)
            0: return {1'b0, (b >= 32'd128) ? b + 32'hFFFF_FF00 : b};
            4: return {1'b0, b};
            1: return {1'b0, (h >= 32'd32768) ? h + 32'hFFFF_0000 : h};
            5: return {1'b0, h};
            2: return {1'b0, d};
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    function automatic bit ref_ready(input logic is_load);
        return !rst && !m_hold && !(is_load && pend_q.size() == LD_DEPTH);
    endfunction

    function automatic logic [31:0] ref_busy();
        logic [31:0] m = 32'd0;
        foreach (pend_q[i]) if (pend_q[i].rd != 0) m = m | (32'd1 << pend_q[i].rd);
        return m;
    endfunction

    task automatic model_step();
        bit          xfer;
        ld_t         p;
        logic [32:0] r;
        if (rst) begin
            pend_q.delete();
            m_hold = 0; m_err = 0; m_wr_en = 0; m_wr_addr = 0; m_wr_data = 0;
            return;
        end
        xfer    = ex_valid && ref_ready(ex_is_load);
        m_wr_en = 0;
        if (mem_rsp_valid) begin
            if (pend_q.size() == 0) begin
                m_err = 1;
            end else begin
                p = pend_q.pop_front();
                r = ref_load(p.f3, p.lo, mem_rsp_data);
                if (r[32]) m_err = 1;
                if (p.rd != 0) begin
                    m_wr_en = 1; m_wr_addr = p.rd; m_wr_data = r[31:0];
                end
            end
            if (xfer && !ex_is_load && ex_rd != 0) begin
                m_hold = 1; m_hold_rd = ex_rd; m_hold_data = ex_data;
            end
        end else if (m_hold) begin
            m_wr_en = 1; m_wr_addr = m_hold_rd; m_wr_data = m_hold_data; m_hold = 0;
        end else if (xfer && !ex_is_load && ex_rd != 0) begin
            m_wr_en = 1; m_wr_addr = ex_rd; m_wr_data = ex_data;
        end
        if (xfer && ex_is_load) pend_q.push_back('{rd: int'(ex_rd), f3: int'(ex_f3), lo: int'(ex_lo)});
    endtask

    // Per-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("ex_ready", {31'd0, ex_ready}, {31'd0, ref_ready(ex_is_load)});
            check("wr_en", {31'd0, wr_en}, {31'd0, m_wr_en});
            if (m_wr_en) begin
                check("wr_addr", {27'd0, wr_addr}, m_wr_addr);
                check("wr_data", wr_data, m_wr_data);
            end
            check("err_flag", {31'd0, err_flag}, {31'd0, m_err});
            check("ld_count", {29'd0, ld_count}, pend_q.size());
            check("busy_mask", busy_mask, ref_busy());
        end
    end

    task automatic drive(input logic v, input logic ld, input logic [4:0] rd, input logic [31:0] dat,
                         input logic [2:0] f3, input logic [1:0] lo, input logic rsp, input logic [31:0] rdat);
        ex_valid = v; ex_is_load = ld; ex_rd = rd; ex_data = dat;
        ex_f3 = f3; ex_lo = lo; mem_rsp_valid = rsp; mem_rsp_data = rdat;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic tick(input logic v, input logic ld, input logic [4:0] rd, input logic [31:0] dat,
                        input logic [2:0] f3, input logic [1:0] lo, input logic rsp, input logic [31:0] rdat);
        drive(v, ld, rd, dat, f3, lo, rsp, rdat);
        step();
    endtask

    task automatic idle();
        tick(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        idle();
        rst = 1'b0;
    endtask

    logic [2:0] legal_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0] bad_f3   [3] = '{3'b011, 3'b110, 3'b111};

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("ready_in_reset", {31'd0, ex_ready}, 32'd0);
        step();
        step();
        rst = 1'b0;
        check("rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("rst_wr_addr", {27'd0, wr_addr}, 32'd0);
        check("rst_wr_data", wr_data, 32'd0);
        check("rst_err", {31'd0, err_flag}, 32'd0);
        check("rst_ld_count", {29'd0, ld_count}, 32'd0);
        cmp_en = 1'b1;

        // ALU only
        drive(1, 0, 5, 32'h1234_5678, 0, 0, 0, 0);
        #1;
        check("alu_ready", {31'd0, ex_ready}, 32'd1);
        step();
        check("alu_wr_en", {31'd0, wr_en}, 32'd1);
        check("alu_wr_addr", {27'd0, wr_addr}, 32'd5);
        check("alu_wr_data", wr_data, 32'h1234_5678);
        $display("tx alu rd=5 data=%08h", wr_data);

        // LB sign-extended byte 2
        tick(1, 1, 3, 0, 3'b000, 2'd2, 0, 0);
        check("lb_busy", busy_mask, 32'h0000_0008);
        tick(0, 0, 0, 0, 0, 0, 1, 32'h0080_0000);
        check("lb_wr_addr", {27'd0, wr_addr}, 32'd3);
        check("lb_wr_data", wr_data, 32'hFFFF_FF80);
        check("lb_busy_clr", busy_mask, 32'd0);
        $display("tx lb rd=3 data=%08h", wr_data);

        // Collision: LHU response against an ALU result
        tick(1, 1, 9, 0, 3'b101, 2'd2, 0, 0);
        drive(1, 0, 7, 32'hA, 0, 0, 1, 32'hBEEF_0000);
        #1;
        check("col_ready", {31'd0, ex_ready}, 32'd1);
        step();
        check("col_wr1_addr", {27'd0, wr_addr}, 32'd9);
        check("col_wr1_data", wr_data, 32'h0000_BEEF);
        drive(1, 0, 8, 32'h55, 0, 0, 0, 0);
        #1;
        check("col_hold_ready", {31'd0, ex_ready}, 32'd0);
        step();
        check("col_wr2_en", {31'd0, wr_en}, 32'd1);
        check("col_wr2_addr", {27'd0, wr_addr}, 32'd7);
        check("col_wr2_data", wr_data, 32'h0000_000A);
        $display("tx collision rd9 then rd7");
        idle();

        // FIFO full
        tick(1, 1, 1, 0, 3'b010, 0, 0, 0);
        tick(1, 1, 2, 0, 3'b010, 0, 0, 0);
        tick(1, 1, 3, 0, 3'b010, 0, 0, 0);
        tick(1, 1, 1, 0, 3'b010, 0, 0, 0);
        check("full_count", {29'd0, ld_count}, 32'd4);
        drive(1, 1, 4, 0, 3'b010, 0, 0, 0);
        #1;
        check("full_load_ready", {31'd0, ex_ready}, 32'd0);
        drive(1, 0, 10, 32'h77, 0, 0, 0, 0);
        #1;
        check("full_alu_ready", {31'd0, ex_ready}, 32'd1);
        step();
        check("full_alu_addr", {27'd0, wr_addr}, 32'd10);
        tick(0, 0, 0, 0, 0, 0, 1, 32'h1111_1111);
        check("full_busy1", busy_mask, 32'h0000_000E);
        tick(0, 0, 0, 0, 0, 0, 1, 32'h2222_2222);
        check("full_busy2", busy_mask, 32'h0000_000A);
        tick(0, 0, 0, 0, 0, 0, 1, 32'h3333_3333);
        check("full_busy3", busy_mask, 32'h0000_0002);
        tick(0, 0, 0, 0, 0, 0, 1, 32'h4444_4444);
        check("full_busy4", busy_mask, 32'd0);
        check("full_last_data", wr_data, 32'h4444_4444);
        $display("tx fifo full drained");

        // Orphan response
        tick(0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        check("orphan_wr_en", {31'd0, wr_en}, 32'd0);
        check("orphan_err", {31'd0, err_flag}, 32'd1);
        pulse_reset();
        check("err_cleared", {31'd0, err_flag}, 32'd0);
        // Load to x0
        tick(1, 1, 0, 0, 3'b010, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0, 1, 32'h1234_5678);
        check("x0_wr_en", {31'd0, wr_en}, 32'd0);
        check("x0_count", {29'd0, ld_count}, 32'd0);
        // Illegal funct3
        tick(1, 1, 4, 0, 3'b011, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF);
        check("ill_wr_en", {31'd0, wr_en}, 32'd1);
        check("ill_wr_addr", {27'd0, wr_addr}, 32'd4);
        check("ill_wr_data", wr_data, 32'd0);
        check("ill_err", {31'd0, err_flag}, 32'd1);
        $display("tx error cases done");

        // Reset mid-operation
        pulse_reset();
        tick(1, 1, 6, 0, 3'b010, 0, 0, 0);
        tick(1, 1, 12, 0, 3'b010, 0, 0, 0);
        rst = 1'b1;
        tick(0, 0, 0, 0, 0, 0, 1, 32'h5555_5555);
        rst = 1'b0;
        check("mid_rst_count", {29'd0, ld_count}, 32'd0);
        check("mid_rst_busy", busy_mask, 32'd0);
        check("mid_rst_wr_en", {31'd0, wr_en}, 32'd0);
        tick(0, 0, 0, 0, 0, 0, 1, 32'h6666_6666);
        check("mid_rst_err", {31'd0, err_flag}, 32'd1);
        $display("tx reset mid-operation done");

        // Randomized traffic against the model
        pulse_reset();
        for (int n = 0; n < 3000; n++) begin
            logic        v, ld, rsp;
            logic [4:0]  rd;
            logic [2:0]  f3;
            rst = ($urandom_range(0, 299) == 0);
            v   = ($urandom_range(0, 9) < 6);
            ld  = $urandom_range(0, 1);
            rd  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            f3  = ($urandom_range(0, 59) == 0) ? bad_f3[$urandom_range(0, 2)] : legal_f3[$urandom_range(0, 4)];
            rsp = (pend_q.size() > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 99) == 0);
            tick(v, ld, rd, $urandom, f3, 2'($urandom_range(0, 3)), rsp, $urandom);
            if (wr_en) $display("tx rand n=%0d wr rd=%0d data=%08h", n, wr_addr, wr_data);
        end
        rst = 1'b0;
        idle();
        idle();
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
